dmem_req: RTL and testbench
===========================

Name: dmem_req

Overview:
- Issue end of the data-SRAM interface. Sits at the EX/MEM boundary.
- Turns an EX-stage load/store into a single data_sram request: enable, byte write-enables, address, and lane-replicated write data.
- Detects address misalignment and guarantees each request is issued exactly once under pipeline stalls.
- Captures the one-cycle-late synchronous SRAM read data and holds it until the MEM stage consumes it.

Parameters:
- STALL_W, 6, width of the stall bus; bit 2 = EX held, bit 3 = MEM held, value 1 = Stop.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  pipeline flush (exception/eret)
- stall  input  STALL_W  pipeline stall bus
- ex_mem_op  input  8  one-hot {sb,sh,sw,lb,lbu,lh,lhu,lw}; all-zero = no memory op
- ex_addr  input  32  effective address from ALU
- ex_rt_data  input  32  store source register value
- mem_ld_fire  input  1  MEM stage consumes its load data this cycle (load leaves MEM)
- data_sram_en  output  1  request enable
- data_sram_wen  output  4  byte write enables; 0 for loads
- data_sram_addr  output  32  ex_addr, unmodified
- data_sram_wdata  output  32  lane-replicated store data
- data_sram_rdata  input  32  SRAM read data, valid the cycle after a load request
- ld_rdata  output  32  raw 32-bit load word delivered to MEM
- adel  output  1  load address error
- ades  output  1  store address error
- stallreq_mem  output  1  request EX hold (load blocked by unconsumed prior load)

Behaviour:
- Reset/flush: issued_r=0, state=IDLE, hold_r=0. All request outputs are 0 in the reset cycle.
- Misalignment is combinational:
  - adel = (lh|lhu)&addr[0] | lw&(addr[1:0]!=0).
  - ades = sh&addr[0] | sw&(addr[1:0]!=0).
  - A misaligned op never asserts data_sram_en.
- Store formatting:
  - sb: wen=4'b0001<<addr[1:0], wdata={4{rt[7:0]}}.
  - sh: wen=addr[1]?4'b1100:4'b0011, wdata={2{rt[15:0]}}.
  - sw: wen=4'b1111, wdata=rt.
  - Loads and no-op: wen=0, wdata=0.
- issue = op!=0 & !adel & !ades & !flush & !issued_r & (load ? ld_ok : 1).
  - ld_ok = (state==IDLE) | mem_ld_fire.
  - data_sram_en = issue. wen and wdata are gated by issue.
- Issue-once rule:
  - issued_r sets at the clock edge where issue=1 and stall[2]=Stop.
  - issued_r clears when stall[2]=NoStop, or on flush.
  - While issued_r=1, data_sram_en=0.
- stallreq_mem = load op & !adel & !issued_r & !ld_ok & !flush.
- Load-data FSM, states IDLE, WAIT_DATA, HELD:
  - IDLE: on load issue -> WAIT_DATA. A store issue leaves the state unchanged.
  - WAIT_DATA: hold_r <= data_sram_rdata.
    - If mem_ld_fire: go to WAIT_DATA when a new load issues this cycle, else IDLE.
    - If not mem_ld_fire: go to HELD.
  - HELD: when mem_ld_fire, go to WAIT_DATA if a new load issues this cycle, else IDLE.
  - flush wins over all transitions -> IDLE.
- ld_rdata = (state==WAIT_DATA) ? data_sram_rdata : hold_r. Latency: data visible the cycle after issue.
- Simultaneous events:
  - flush with a valid op: no request, and issued_r cleared.
  - rst mid-WAIT_DATA: data discarded, state IDLE.

Test Plan:
- sb, addr=0x1003, rt=0x000000A5 -> en=1, wen=4'b1000, wdata=0xA5A5A5A5, addr=0x1003, single cycle.
- sw, addr=0x2000, rt=0x12345678, stall[2]=Stop for 3 cycles -> en=1 only in the first cycle, 0 in the next 2; issued_r clears when the stall drops.
- lw, addr=0x2002 -> adel=1, en=0. sh, addr=0x2001 -> ades=1, en=0, wen=0.
- lw, addr=0x3000; next cycle rdata=0xDEADBEEF with mem_ld_fire=0 for 2 cycles, then 1 -> ld_rdata=0xDEADBEEF throughout; state WAIT_DATA -> HELD -> HELD -> IDLE.
- Back-to-back lw at 0x40 and 0x44 with mem_ld_fire=1 in cycle 2 -> second load issues in cycle 2, no stallreq_mem, ld_rdata tracks each word. Repeat with mem_ld_fire=0 -> stallreq_mem=1, en=0 until fire.
- Load issued, flush asserted in the WAIT_DATA cycle -> state IDLE, next op issues normally. rst in the same situation -> all outputs 0, hold_r=0.

Source files
------------

// File: rtl/dmem_req.sv
// Data-SRAM issue stage at the EX/MEM boundary: formats load/store requests,
// flags misaligned addresses, issues each request once, and holds load data for MEM.
module dmem_req #(
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [STALL_W-1:0] stall,
    input  logic [7:0]         ex_mem_op,
    input  logic [31:0]        ex_addr,
    input  logic [31:0]        ex_rt_data,
    input  logic               mem_ld_fire,
    output logic               data_sram_en,
    output logic [3:0]         data_sram_wen,
    output logic [31:0]        data_sram_addr,
    output logic [31:0]        data_sram_wdata,
    input  logic [31:0]        data_sram_rdata,
    output logic [31:0]        ld_rdata,
    output logic               adel,
    output logic               ades,
    output logic               stallreq_mem
);

    localparam logic STOP = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        HELD      = 2'd2
    } ld_state_e;

    // st_op is {sb, sh, sw}
    function automatic logic [3:0] store_wen(input logic [2:0] st_op, input logic [1:0] a);
        logic [3:0] w;
        case (st_op)
            3'b100:  w = 4'b0001 << a;
            3'b010:  w = a[1] ? 4'b1100 : 4'b0011;
            3'b001:  w = 4'b1111;
            default: w = 4'b0000;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] st_op, input logic [31:0] rt);
        logic [31:0] d;
        case (st_op)
            3'b100:  d = {4{rt[7:0]}};
            3'b010:  d = {2{rt[15:0]}};
            3'b001:  d = rt;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    ld_state_e   state_r;
    ld_state_e   state_n;
    logic        issued_r;
    logic        issued_n;
    logic [31:0] hold_r;
    logic [31:0] hold_n;

    logic        is_sh_s;
    logic        is_sw_s;
    logic        is_half_ld_s;
    logic        is_lw_s;
    logic        load_s;
    logic        op_valid_s;
    logic        adel_s;
    logic        ades_s;
    logic        ld_ok_s;
    logic        issue_s;
    logic        ld_issue_s;
    logic        unused_stall_s;

    assign is_sh_s      = ex_mem_op[6];
    assign is_sw_s      = ex_mem_op[5];
    assign is_half_ld_s = ex_mem_op[2] | ex_mem_op[1];
    assign is_lw_s      = ex_mem_op[0];
    assign load_s       = |ex_mem_op[4:0];
    assign op_valid_s   = |ex_mem_op;

    assign adel_s = (is_half_ld_s & ex_addr[0]) | (is_lw_s & (ex_addr[1:0] != 2'b00));
    assign ades_s = (is_sh_s & ex_addr[0]) | (is_sw_s & (ex_addr[1:0] != 2'b00));

    // A load may only go out once the previous load's data slot is free or being drained.
    assign ld_ok_s    = (state_r == IDLE) | mem_ld_fire;
    assign issue_s    = !rst & op_valid_s & !adel_s & !ades_s & !flush & !issued_r
                        & (load_s ? ld_ok_s : 1'b1);
    assign ld_issue_s = issue_s & load_s;

    assign data_sram_en    = issue_s;
    assign data_sram_wen   = issue_s ? store_wen(ex_mem_op[7:5], ex_addr[1:0]) : 4'b0000;
    assign data_sram_wdata = issue_s ? store_wdata(ex_mem_op[7:5], ex_rt_data) : 32'h0000_0000;
    assign data_sram_addr  = rst ? 32'h0000_0000 : ex_addr;

    assign adel         = adel_s;
    assign ades         = ades_s;
    assign stallreq_mem = !rst & load_s & !adel_s & !issued_r & !ld_ok_s & !flush;
    assign ld_rdata     = rst ? 32'h0000_0000
                              : ((state_r == WAIT_DATA) ? data_sram_rdata : hold_r);

    assign unused_stall_s = ^{stall[STALL_W-1:3], stall[1:0]};

    // Next-state logic for the issue-once flag, the load-data FSM and the hold register.
    always_comb begin
        issued_n = issued_r;
        hold_n   = hold_r;
        state_n  = state_r;

        if (flush) begin
            issued_n = 1'b0;
        end else if (stall[2] != STOP) begin
            issued_n = 1'b0;
        end else if (issue_s) begin
            issued_n = 1'b1;
        end else begin
            issued_n = issued_r;
        end

        if (flush) begin
            hold_n = 32'h0000_0000;
        end else if (state_r == WAIT_DATA) begin
            hold_n = data_sram_rdata;
        end else begin
            hold_n = hold_r;
        end

        case (state_r)
            IDLE: begin
                if (ld_issue_s) begin
                    state_n = WAIT_DATA;
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT_DATA: begin
                if (mem_ld_fire) begin
                    state_n = ld_issue_s ? WAIT_DATA : IDLE;
                end else begin
                    state_n = HELD;
                end
            end
            HELD: begin
                if (mem_ld_fire) begin
                    state_n = ld_issue_s ? WAIT_DATA : IDLE;
                end else begin
                    state_n = HELD;
                end
            end
            default: state_n = IDLE;
        endcase

        if (flush) begin
            state_n = IDLE;
        end else begin
            state_n = state_n;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            issued_r <= 1'b0;
            hold_r   <= 32'h0000_0000;
        end else begin
            state_r  <= state_n;
            issued_r <= issued_n;
            hold_r   <= hold_n;
        end
    end

endmodule

// File: tb/tb_dmem_req.sv
// Directed self-checking bench for dmem_req: formatting, misalignment,
// issue-once under stall, load-data FSM, flush and reset.
module tb_dmem_req;

    localparam int STALL_W = 6;
    localparam logic [7:0] OP_NONE = 8'h00;
    localparam logic [7:0] OP_SB   = 8'h80;
    localparam logic [7:0] OP_SH   = 8'h40;
    localparam logic [7:0] OP_SW   = 8'h20;
    localparam logic [7:0] OP_LW   = 8'h01;

    logic               clk;
    logic               rst;
    logic               flush;
    logic [STALL_W-1:0] stall;
    logic [7:0]         ex_mem_op;
    logic [31:0]        ex_addr;
    logic [31:0]        ex_rt_data;
    logic               mem_ld_fire;
    logic               data_sram_en;
    logic [3:0]         data_sram_wen;
    logic [31:0]        data_sram_addr;
    logic [31:0]        data_sram_wdata;
    logic [31:0]        data_sram_rdata;
    logic [31:0]        ld_rdata;
    logic               adel;
    logic               ades;
    logic               stallreq_mem;

    int err_cnt = 0;
    int chk_cnt = 0;

    dmem_req #(.STALL_W(STALL_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .stall           (stall),
        .ex_mem_op       (ex_mem_op),
        .ex_addr         (ex_addr),
        .ex_rt_data      (ex_rt_data),
        .mem_ld_fire     (mem_ld_fire),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .ld_rdata        (ld_rdata),
        .adel            (adel),
        .ades            (ades),
        .stallreq_mem    (stallreq_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs on the falling edge; outputs settle 1ns later.
    task automatic cyc(input logic r, input logic fl, input logic st2, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] rt, input logic fire,
                       input logic [31:0] rd);
        @(negedge clk);
        rst             = r;
        flush           = fl;
        stall           = '0;
        stall[2]        = st2;
        ex_mem_op       = op;
        ex_addr         = a;
        ex_rt_data      = rt;
        mem_ld_fire     = fire;
        data_sram_rdata = rd;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = '0; ex_mem_op = OP_NONE; ex_addr = 32'h0;
        ex_rt_data = 32'h0; mem_ld_fire = 1'b0; data_sram_rdata = 32'h0;

        // Reset cycle with a valid store presented: nothing may go out
        cyc(1'b1, 1'b0, 1'b0, OP_SB, 32'h1003, 32'hA5, 1'b0, 32'h1234_5678);
        check_val("rst_en",    {31'd0, data_sram_en}, 32'd0);
        check_val("rst_wen",   {28'd0, data_sram_wen}, 32'd0);
        check_val("rst_wdata", data_sram_wdata, 32'd0);
        check_val("rst_addr",  data_sram_addr, 32'd0);
        check_val("rst_ldr",   ld_rdata, 32'd0);
        check_val("rst_sreq",  {31'd0, stallreq_mem}, 32'd0);

        // sb at byte 3
        cyc(1'b0, 1'b0, 1'b0, OP_SB, 32'h1003, 32'h0000_00A5, 1'b0, 32'h0);
        check_val("sb_en",    {31'd0, data_sram_en}, 32'd1);
        check_val("sb_wen",   {28'd0, data_sram_wen}, 32'h8);
        check_val("sb_wdata", data_sram_wdata, 32'hA5A5_A5A5);
        check_val("sb_addr",  data_sram_addr, 32'h1003);
        cyc(1'b0, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 32'h0);
        check_val("nop_en",   {31'd0, data_sram_en}, 32'd0);

        // sw held by a 3-cycle EX stall: one request only
        cyc(1'b0, 1'b0, 1'b1, OP_SW, 32'h2000, 32'h1234_5678, 1'b0, 32'h0);
        check_val("sw_en0",    {31'd0, data_sram_en}, 32'd1);
        check_val("sw_wen0",   {28'd0, data_sram_wen}, 32'hF);
        check_val("sw_wdata0", data_sram_wdata, 32'h1234_5678);
        for (int i = 1; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, OP_SW, 32'h2000, 32'h1234_5678, 1'b0, 32'h0);
            check_val($sformatf("sw_en%0d", i), {31'd0, data_sram_en}, 32'd0);
            check_val($sformatf("sw_wen%0d", i), {28'd0, data_sram_wen}, 32'd0);
        end
        cyc(1'b0, 1'b0, 1'b0, OP_SW, 32'h2000, 32'h1234_5678, 1'b0, 32'h0);
        check_val("sw_release_en", {31'd0, data_sram_en}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, OP_SW, 32'h2004, 32'h0000_BEEF, 1'b0, 32'h0);
        check_val("sw_next_en", {31'd0, data_sram_en}, 32'd1);

        // Misalignment and halfword formatting
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h2002, 32'h0, 1'b0, 32'h0);
        check_val("lw_mis_adel", {31'd0, adel}, 32'd1);
        check_val("lw_mis_en",   {31'd0, data_sram_en}, 32'd0);
        check_val("lw_mis_sreq", {31'd0, stallreq_mem}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, OP_SH, 32'h2001, 32'hAAAA_1234, 1'b0, 32'h0);
        check_val("sh_mis_ades", {31'd0, ades}, 32'd1);
        check_val("sh_mis_en",   {31'd0, data_sram_en}, 32'd0);
        check_val("sh_mis_wen",  {28'd0, data_sram_wen}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, OP_SH, 32'h2002, 32'hAAAA_1234, 1'b0, 32'h0);
        check_val("sh_ades",  {31'd0, ades}, 32'd0);
        check_val("sh_wen",   {28'd0, data_sram_wen}, 32'hC);
        check_val("sh_wdata", data_sram_wdata, 32'h1234_1234);

        // lw, data held across two cycles without fire
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h3000, 32'h0, 1'b0, 32'h0);
        check_val("lw_en",  {31'd0, data_sram_en}, 32'd1);
        check_val("lw_wen", {28'd0, data_sram_wen}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        check_val("lw_wait", ld_rdata, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 32'h1111_1111);
        check_val("lw_held1", ld_rdata, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b1, 32'h2222_2222);
        check_val("lw_held2", ld_rdata, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h3004, 32'h0, 1'b0, 32'h0);
        check_val("lw_idle_en",   {31'd0, data_sram_en}, 32'd1);
        check_val("lw_idle_sreq", {31'd0, stallreq_mem}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b1, 32'h0BAD_F00D);
        check_val("lw2_data", ld_rdata, 32'h0BAD_F00D);

        // Back-to-back loads, consumer ready
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h40, 32'h0, 1'b0, 32'h0);
        check_val("b2b_en0", {31'd0, data_sram_en}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h44, 32'h0, 1'b1, 32'hA0A0_A0A0);
        check_val("b2b_en1",   {31'd0, data_sram_en}, 32'd1);
        check_val("b2b_sreq1", {31'd0, stallreq_mem}, 32'd0);
        check_val("b2b_d0",    ld_rdata, 32'hA0A0_A0A0);
        cyc(1'b0, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b1, 32'hB4B4_B4B4);
        check_val("b2b_d1",    ld_rdata, 32'hB4B4_B4B4);

        // Back-to-back loads, consumer not ready: second load blocked
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h40, 32'h0, 1'b0, 32'h0);
        check_val("blk_en0", {31'd0, data_sram_en}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h44, 32'h0, 1'b0, 32'hC0C0_C0C0);
        check_val("blk_en1",   {31'd0, data_sram_en}, 32'd0);
        check_val("blk_sreq1", {31'd0, stallreq_mem}, 32'd1);
        check_val("blk_d1",    ld_rdata, 32'hC0C0_C0C0);
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h44, 32'h0, 1'b0, 32'h3333_3333);
        check_val("blk_en2",   {31'd0, data_sram_en}, 32'd0);
        check_val("blk_sreq2", {31'd0, stallreq_mem}, 32'd1);
        check_val("blk_d2",    ld_rdata, 32'hC0C0_C0C0);
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h44, 32'h0, 1'b1, 32'h4444_4444);
        check_val("blk_en3",   {31'd0, data_sram_en}, 32'd1);
        check_val("blk_sreq3", {31'd0, stallreq_mem}, 32'd0);
        check_val("blk_d3",    ld_rdata, 32'hC0C0_C0C0);
        cyc(1'b0, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b1, 32'hD4D4_D4D4);
        check_val("blk_d4",    ld_rdata, 32'hD4D4_D4D4);

        // Flush during WAIT_DATA, with a valid store presented
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h50, 32'h0, 1'b0, 32'h0);
        check_val("fl_ld_en", {31'd0, data_sram_en}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, OP_SW, 32'h58, 32'hFFFF_0000, 1'b0, 32'h5555_5555);
        check_val("fl_en",  {31'd0, data_sram_en}, 32'd0);
        check_val("fl_wen", {28'd0, data_sram_wen}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 32'h6666_6666);
        check_val("fl_hold", ld_rdata, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h60, 32'h0, 1'b0, 32'h0);
        check_val("fl_next_en", {31'd0, data_sram_en}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b1, 32'h6060_6060);
        check_val("fl_next_d", ld_rdata, 32'h6060_6060);

        // Flush clears the issue-once flag while EX stays stalled
        cyc(1'b0, 1'b0, 1'b1, OP_SW, 32'h80, 32'h8888_8888, 1'b0, 32'h0);
        check_val("fli_en0", {31'd0, data_sram_en}, 32'd1);
        cyc(1'b0, 1'b1, 1'b1, OP_SW, 32'h80, 32'h8888_8888, 1'b0, 32'h0);
        check_val("fli_en1", {31'd0, data_sram_en}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, OP_SW, 32'h80, 32'h8888_8888, 1'b0, 32'h0);
        check_val("fli_en2", {31'd0, data_sram_en}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 32'h0);

        // Reset during WAIT_DATA discards the data
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h70, 32'h0, 1'b0, 32'h0);
        check_val("rs_ld_en", {31'd0, data_sram_en}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 32'h7777_7777);
        check_val("rs_ldr", ld_rdata, 32'd0);
        check_val("rs_en",  {31'd0, data_sram_en}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 32'h9999_9999);
        check_val("rs_hold", ld_rdata, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, OP_LW, 32'h74, 32'h0, 1'b0, 32'h0);
        check_val("rs_next_en",   {31'd0, data_sram_en}, 32'd1);
        check_val("rs_next_sreq", {31'd0, stallreq_mem}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
